register_bank_arbiter: RTL and testbench



---
 rtl/register_bank_arbiter_pkg.sv | 27 ++
 rtl/register_bank_arbiter_rr_arbiter.sv | 59 +++++
 rtl/register_bank_arbiter.sv | 136 +++++++++++++
 tb/tb_register_bank_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/register_bank_arbiter_pkg.sv
// Shared register-bank mapping helpers and response tag type.
// The register file and writeback path use the same bank mapping.
package bgpu_pkg;

  localparam int unsigned TagIdxWidth = 8;

  typedef struct packed {
    logic                   valid;
    logic [TagIdxWidth-1:0] req_idx;
  } rsp_tag_t;

  // Warp-swizzled bank select: low bank bits of (reg_idx + wid), carry dropped.
  function automatic int unsigned reg_bank_sel(input int unsigned wid,
                                               input int unsigned reg_idx,
                                               input int unsigned num_banks);
    return (wid + reg_idx) & (num_banks - 1);
  endfunction

  // Bank-local row: {wid, reg_idx[RegIdxWidth-1:BankBits]}.
  function automatic int unsigned reg_bank_row(input int unsigned wid,
                                               input int unsigned reg_idx,
                                               input int unsigned reg_idx_width,
                                               input int unsigned bank_bits);
    return (wid << (reg_idx_width - bank_bits)) | (reg_idx >> bank_bits);
  endfunction

endpackage

// File: rtl/register_bank_arbiter_rr_arbiter.sv
// NumReq-way round-robin arbiter with pointer register and hold input.
// hold_i suppresses the grant and freezes the pointer for that cycle.
module reg_bank_rr_arbiter #(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned IdxWidth = $clog2(NumReq)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumReq-1:0]   req_i,
  input  logic                hold_i,
  output logic [NumReq-1:0]   gnt_o,
  output logic                gnt_valid_o,
  output logic [IdxWidth-1:0] gnt_idx_o
);

  logic [IdxWidth-1:0] ptr_q, ptr_d;

  // Scan from the pointer upward with wrap; first valid candidate wins.
  always_comb begin
    logic                found;
    logic [IdxWidth-1:0] cand;
    int unsigned         idx;
    found       = 1'b0;
    cand        = '0;
    idx         = 0;
    gnt_o       = '0;
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    if (!hold_i) begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        idx = 32'(ptr_q) + i;
        if (idx >= NumReq) idx = idx - NumReq;
        cand = IdxWidth'(idx);
        if (!found && req_i[cand]) begin
          found       = 1'b1;
          gnt_valid_o = 1'b1;
          gnt_idx_o   = cand;
          gnt_o[cand] = 1'b1;
        end
      end
    end
  end

  // Pointer moves past the winner on a grant, otherwise holds.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_valid_o) begin
      if (gnt_idx_o == IdxWidth'(NumReq - 1)) ptr_d = '0;
      else                                    ptr_d = gnt_idx_o + IdxWidth'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/register_bank_arbiter.sv
// Banked warp register file read arbiter: maps each read to a swizzled bank,
// grants one requester per bank per cycle (round-robin), and routes the
// fixed-latency bank data back. Optional per-bank conflict counters are
// enabled with REG_BANK_ARB_PERF_COUNTERS_EN.
module register_bank_arbiter
  import bgpu_pkg::*;
#(
  parameter int unsigned NumRequesters = 4,
  parameter int unsigned NumBanks      = 4,
  parameter int unsigned NumWarps      = 8,
  parameter int unsigned WarpWidth     = 32,
  parameter int unsigned RegIdxWidth   = 6,
  parameter int unsigned RegWidth      = 32,
  parameter int unsigned ReadLatency   = 1,
  parameter int unsigned BankBits      = $clog2(NumBanks),
  parameter int unsigned WidWidth      = NumWarps > 1 ? $clog2(NumWarps) : 1,
  parameter int unsigned ReqIdxWidth   = $clog2(NumRequesters),
  parameter int unsigned BankAddrWidth = WidWidth + RegIdxWidth - BankBits,
  parameter int unsigned DataWidth     = RegWidth * WarpWidth
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic [NumRequesters-1:0]                    req_valid_i,
  input  logic [NumRequesters-1:0][WidWidth-1:0]      req_wid_i,
  input  logic [NumRequesters-1:0][RegIdxWidth-1:0]   req_reg_idx_i,
  output logic [NumRequesters-1:0]                    req_ready_o,
  output logic [NumRequesters-1:0]                    rsp_valid_o,
  output logic [NumRequesters-1:0][DataWidth-1:0]     rsp_data_o,
  output logic [NumBanks-1:0]                         bank_req_valid_o,
  output logic [NumBanks-1:0][BankAddrWidth-1:0]      bank_addr_o,
  input  logic [NumBanks-1:0][DataWidth-1:0]          bank_rdata_i,
  input  logic [NumBanks-1:0]                         bank_write_busy_i,
  output logic [NumBanks-1:0][31:0]                   perf_conflict_cnt_o
);

  logic [NumRequesters-1:0][BankBits-1:0]      sel;
  logic [NumRequesters-1:0][BankAddrWidth-1:0] row;
  logic [NumBanks-1:0][NumRequesters-1:0]      bank_req, bank_gnt;
  logic [NumBanks-1:0]                         gnt_vld, hold;
  logic [NumBanks-1:0][ReqIdxWidth-1:0]        gnt_idx;
  rsp_tag_t [NumBanks-1:0][ReadLatency-1:0]    tag_q;

  // Bank select and row for every requester.
  always_comb begin
    for (int unsigned r = 0; r < NumRequesters; r++) begin
      sel[r] = BankBits'(reg_bank_sel(32'(req_wid_i[r]), 32'(req_reg_idx_i[r]), NumBanks));
      row[r] = BankAddrWidth'(reg_bank_row(32'(req_wid_i[r]), 32'(req_reg_idx_i[r]),
                                           RegIdxWidth, BankBits));
    end
  end

  // Per-bank candidate vectors.
  always_comb begin
    for (int unsigned b = 0; b < NumBanks; b++)
      for (int unsigned r = 0; r < NumRequesters; r++)
        bank_req[b][r] = req_valid_i[r] && (sel[r] == BankBits'(b));
  end

  // Reset blocks grants the same way writeback does.
  assign hold = bank_write_busy_i | {NumBanks{~rst_ni}};

  reg_bank_rr_arbiter #(
    .NumReq  (NumRequesters),
    .IdxWidth(ReqIdxWidth)
  ) u_arb [NumBanks-1:0] (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (bank_req),
    .hold_i     (hold),
    .gnt_o      (bank_gnt),
    .gnt_valid_o(gnt_vld),
    .gnt_idx_o  (gnt_idx)
  );

  // Ready per requester and bank-side read enables/rows.
  always_comb begin
    req_ready_o      = '0;
    bank_req_valid_o = gnt_vld;
    bank_addr_o      = '0;
    for (int unsigned b = 0; b < NumBanks; b++) begin
      req_ready_o = req_ready_o | bank_gnt[b];
      if (gnt_vld[b]) bank_addr_o[b] = row[gnt_idx[b]];
    end
  end

  // Response tag shift register, one per bank, matching the bank latency.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tag_q <= '0;
    end else begin
      for (int unsigned b = 0; b < NumBanks; b++) begin
        tag_q[b][0] <= '{valid: gnt_vld[b], req_idx: TagIdxWidth'(gnt_idx[b])};
        for (int unsigned i = 1; i < ReadLatency; i++) tag_q[b][i] <= tag_q[b][i-1];
      end
    end
  end

  // Route tail-of-pipe bank data to the tagged requester.
  always_comb begin
    rsp_tag_t tail;
    tail        = '0;
    rsp_valid_o = '0;
    rsp_data_o  = '0;
    for (int unsigned b = 0; b < NumBanks; b++) begin
      tail = tag_q[b][ReadLatency-1];
      for (int unsigned r = 0; r < NumRequesters; r++) begin
        if (rst_ni && tail.valid && tail.req_idx == TagIdxWidth'(r)) begin
          rsp_valid_o[r] = 1'b1;
          rsp_data_o[r]  = bank_rdata_i[b];
        end
      end
    end
  end

`ifdef REG_BANK_ARB_PERF_COUNTERS_EN
  logic [NumBanks-1:0][31:0] cnt_q, cnt_d;

  // Count cycles where some valid request to the bank went ungranted.
  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned b = 0; b < NumBanks; b++)
      if (|(bank_req[b] & ~bank_gnt[b]) && cnt_q[b] != '1) cnt_d[b] = cnt_q[b] + 32'd1;
  end

  // Conflict counter registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign perf_conflict_cnt_o = cnt_q;
`else
  assign perf_conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_register_bank_arbiter.sv
// Directed bench for register_bank_arbiter with hand-computed expectations.
module tb_register_bank_arbiter;

  localparam int NR = 4, NB = 4, DW = 1024;

  logic                    clk_i = 1'b0;
  logic                    rst_ni;
  logic [NR-1:0]           req_valid_i;
  logic [NR-1:0][2:0]      req_wid_i;
  logic [NR-1:0][5:0]      req_reg_idx_i;
  logic [NR-1:0]           req_ready_o;
  logic [NR-1:0]           rsp_valid_o;
  logic [NR-1:0][DW-1:0]   rsp_data_o;
  logic [NB-1:0]           bank_req_valid_o;
  logic [NB-1:0][6:0]      bank_addr_o;
  logic [NB-1:0][DW-1:0]   bank_rdata_i;
  logic [NB-1:0]           bank_write_busy_i;
  logic [NB-1:0][31:0]     perf_conflict_cnt_o;

  int checks = 0, errors = 0;

  register_bank_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_wid_i(req_wid_i), .req_reg_idx_i(req_reg_idx_i),
    .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
    .bank_req_valid_o(bank_req_valid_o), .bank_addr_o(bank_addr_o),
    .bank_rdata_i(bank_rdata_i), .bank_write_busy_i(bank_write_busy_i),
    .perf_conflict_cnt_o(perf_conflict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Inputs change 2 time units after the edge; checks 1 unit later.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic set_req(input int r, input logic [2:0] w, input logic [5:0] g);
    req_wid_i[r]     = w;
    req_reg_idx_i[r] = g;
  endtask

  function automatic logic [63:0] exp_lo(input int b);
    logic [7:0] h;
    h = 8'hB0 + 8'(b);
    return {h, 24'd1, h, 24'd0};
  endfunction

  initial begin
    logic [3:0] m;
    #100000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] m;
    for (int b = 0; b < NB; b++)
      for (int j = 0; j < 32; j++)
        bank_rdata_i[b][j*32 +: 32] = {8'hB0 + 8'(b), 24'(j)};
    rst_ni = 1'b0;
    bank_write_busy_i = '0;
    for (int r = 0; r < NR; r++) set_req(r, 3'd0, 6'(r));
    req_valid_i = 4'b1111;
    #3;
    chk("rst_ready",  64'(req_ready_o), 64'h0);
    chk("rst_bvalid", 64'(bank_req_valid_o), 64'h0);
    chk("rst_rsp",    64'(rsp_valid_o), 64'h0);
    chk("rst_addr",   64'(bank_addr_o), 64'h0);
    tick();
    tick();
    rst_ni = 1'b1;
    req_valid_i = '0;

    // Single request wid=1 reg=5 -> bank 2, row 0x11.
    set_req(0, 3'd1, 6'd5);
    req_valid_i = 4'b0001;
    #1;
    chk("t1_ready",  64'(req_ready_o), 64'h1);
    chk("t1_bvalid", 64'(bank_req_valid_o), 64'h4);
    chk("t1_addr",   64'(bank_addr_o[2]), 64'h11);
    tick(); req_valid_i = '0; #1;
    chk("t1_rsp",    64'(rsp_valid_o), 64'h1);
    chk("t1_data",   rsp_data_o[0][63:0], exp_lo(2));
    chk("t1_dtop",   64'(rsp_data_o[0][DW-1 -: 32]), {32'h0, 8'hB2, 24'd31});
    tick(); #1;
    chk("t1_rsp_gone", 64'(rsp_valid_o), 64'h0);

    // All four on bank 0: round-robin 0,1,2,3, responses one cycle later.
    for (int r = 0; r < NR; r++) set_req(r, 3'd0, 6'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      m = 4'b1111 << i;
      req_valid_i = m;
      #1;
      chk($sformatf("t2_ready%0d", i), 64'(req_ready_o), 64'(1 << i));
      chk($sformatf("t2_rsp%0d", i),   64'(rsp_valid_o), (i > 0) ? 64'(1 << (i - 1)) : 64'h0);
    end
    tick(); req_valid_i = '0; #1;
    chk("t2_rsp_last", 64'(rsp_valid_o), 64'h8);
    chk("t2_data_last", rsp_data_o[3][63:0], exp_lo(0));

    // One request per bank: all granted in parallel.
    tick();
    for (int r = 0; r < NR; r++) set_req(r, 3'd2, 6'(r + 2));
    req_valid_i = 4'b1111;
    #1;
    chk("t3_ready",  64'(req_ready_o), 64'hF);
    chk("t3_bvalid", 64'(bank_req_valid_o), 64'hF);
    chk("t3_addr0",  64'(bank_addr_o[0]), 64'h20);
    chk("t3_addr3",  64'(bank_addr_o[3]), 64'h21);
    tick(); req_valid_i = '0; #1;
    chk("t3_rsp",    64'(rsp_valid_o), 64'hF);
    chk("t3_data1",  rsp_data_o[1][63:0], exp_lo(1));
    chk("t3_data3",  rsp_data_o[3][63:0], exp_lo(3));

    // Bank 0 write-busy for 3 cycles stalls requester 1.
    set_req(1, 3'd0, 6'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      bank_write_busy_i = 4'b0001;
      req_valid_i = 4'b0010;
      #1;
      chk($sformatf("t4_busy_ready%0d", i),  64'(req_ready_o), 64'h0);
      chk($sformatf("t4_busy_bvalid%0d", i), 64'(bank_req_valid_o), 64'h0);
    end
    tick(); bank_write_busy_i = '0; #1;
    chk("t4_ready",  64'(req_ready_o), 64'h2);
    chk("t4_bvalid", 64'(bank_req_valid_o), 64'h1);
    tick(); req_valid_i = '0; #1;
    chk("t4_rsp",    64'(rsp_valid_o), 64'h2);

    // Reset right after a grant on bank 1: response dropped, pointer cleared.
    tick();
    set_req(2, 3'd0, 6'd1);
    req_valid_i = 4'b0100;
    #1;
    chk("t5_ready", 64'(req_ready_o), 64'h4);
    tick();
    rst_ni = 1'b0;
    set_req(0, 3'd0, 6'd1);
    set_req(3, 3'd0, 6'd1);
    req_valid_i = 4'b1001;
    #1;
    chk("t5_rst_rsp",    64'(rsp_valid_o), 64'h0);
    chk("t5_rst_ready",  64'(req_ready_o), 64'h0);
    chk("t5_rst_bvalid", 64'(bank_req_valid_o), 64'h0);
    tick(); rst_ni = 1'b1; #1;
    chk("t5_post_rsp",   64'(rsp_valid_o), 64'h0);
    chk("t5_post_ready", 64'(req_ready_o), 64'h1);
    tick(); req_valid_i = 4'b1000; #1;
    chk("t5_ready3",     64'(req_ready_o), 64'h8);
    chk("t5_rsp0",       64'(rsp_valid_o), 64'h1);
    tick(); req_valid_i = '0; #1;
    chk("t5_rsp3",       64'(rsp_valid_o), 64'h8);

    // Two requesters contend on bank 3; three cycles leave a loser.
    set_req(0, 3'd0, 6'd3);
    set_req(1, 3'd0, 6'd3);
    for (int i = 0; i < 4; i++) begin
      tick();
      req_valid_i = (i < 3) ? 4'b0011 : 4'b0001;
      #1;
      chk($sformatf("t6_ready%0d", i), 64'(req_ready_o), (i == 1) ? 64'h2 : 64'h1);
    end
    tick(); req_valid_i = '0; #1;
`ifdef REG_BANK_ARB_PERF_COUNTERS_EN
    chk("t6_perf3", 64'(perf_conflict_cnt_o[3]), 64'd3);
`else
    chk("t6_perf3", 64'(perf_conflict_cnt_o[3]), 64'd0);
`endif
    chk("t6_perf0", 64'(perf_conflict_cnt_o[0]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
